led_seq_ctrl: RTL and testbench

Sequencer for the 6-LED demultiplexer: drives its 7-bit index `n` and active-high blank `pulse` to run a single-player "stop the light" game. A lit LED chases across positions 0..5 at a fixed step rate. A `hit` press while the light sits on the target position scores a point and flashes all LEDs. A miss ends the game. The block sits between the debounced button inputs and the LED demultiplexer.

---
 rtl/led_seq_ctrl_pkg.sv | 27 ++
 rtl/led_seq_ctrl_tick_gen.sv | 27 ++
 rtl/led_seq_ctrl.sv | 169 ++++++++++++++++
 tb/tb_led_seq_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/led_seq_ctrl_pkg.sv
// Shared types and constants for the LED chase sequencer.
// State encodings, LED index limits and position stepping helpers.
package led_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLASH = 2'd2
    } state_t;

    localparam logic [6:0] LED_ALL = 7'd6;
    localparam logic [2:0] POS_MIN = 3'd0;
    localparam logic [2:0] POS_MAX = 3'd5;

    function automatic logic [2:0] start_pos(input logic d);
        return d ? POS_MAX : POS_MIN;
    endfunction

    function automatic logic [2:0] pos_step(input logic [2:0] p,
                                            input logic d);
        if (!d)
            return (p == POS_MAX) ? POS_MIN : p + 3'd1;
        else
            return (p == POS_MIN) ? POS_MAX : p - 3'd1;
    endfunction

endpackage

// File: rtl/led_seq_ctrl_tick_gen.sv
// Prescaler: counts 0..period-1 and pulses tick on the last count.
// A clear forces the count back to 0 on the next edge.
module led_tick_gen (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clear,
    input  logic [23:0] i_period,
    output logic        o_tick
);

    logic [23:0] r_cnt;
    logic        w_last;

    // >= keeps the counter bounded if the period ever shrinks
    assign w_last = (r_cnt >= i_period - 24'd1);
    assign o_tick = w_last;

    always_ff @(posedge clk) begin
        if (rst)
            r_cnt <= 24'd0;
        else if (i_clear || w_last)
            r_cnt <= 24'd0;
        else
            r_cnt <= r_cnt + 24'd1;
    end

endmodule

// File: rtl/led_seq_ctrl.sv
// "Stop the light" sequencer driving the 6-LED demux index and blank.
// Optional LED_SEQ_SPEEDUP_EN halves the step period on each hit.
module led_seq_ctrl
    import led_seq_ctrl_pkg::*;
#(
    parameter logic [23:0] TICK_DIV    = 24'd5_000_000,
    parameter logic [2:0]  TARGET      = 3'd5,
    parameter logic [3:0]  FLASH_TICKS = 4'd6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       dir,
    input  logic       hit,
    output logic [6:0] n_out,
    output logic       pulse_out,
    output logic [3:0] score,
    output logic       busy
);

    state_t      r_state;
    state_t      w_next;
    logic [2:0]  r_pos;
    logic [2:0]  w_pos_d;
    logic        r_dir;
    logic [3:0]  r_ftk;
    logic        w_tick;
    logic        w_clr;
    logic        w_go;
    logic        w_score_hit;
    logic        w_flash_end;
    logic        w_step;
    logic [23:0] w_period;
    logic [6:0]  w_n_d;
    logic        w_pulse_d;
    logic        w_busy_d;

    assign w_go        = (r_state == S_IDLE) && start && !stop;
    assign w_score_hit = (r_state == S_RUN) && hit && !stop
                         && (r_pos == TARGET);
    assign w_flash_end = (r_state == S_FLASH) && w_tick && !stop
                         && (r_ftk == FLASH_TICKS - 4'd1);
    assign w_step      = (r_state == S_RUN) && (w_next == S_RUN)
                         && w_tick;
    assign w_clr       = (r_state == S_IDLE) || (w_next == S_IDLE)
                         || w_score_hit || w_flash_end;

`ifdef LED_SEQ_SPEEDUP_EN
    logic [1:0] r_level;
    logic [1:0] r_run_lvl;

    // the running period only picks up the new level on FLASH exit
    always_ff @(posedge clk) begin
        if (rst || w_go) begin
            r_level   <= 2'd0;
            r_run_lvl <= 2'd0;
        end else begin
            if (w_score_hit && r_level != 2'd3)
                r_level <= r_level + 2'd1;
            if (w_flash_end)
                r_run_lvl <= r_level;
        end
    end

    assign w_period = TICK_DIV >> r_run_lvl;
`else
    assign w_period = TICK_DIV;
`endif

    led_tick_gen u_tick (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_clr),
        .i_period (w_period),
        .o_tick   (w_tick)
    );

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (stop) begin
            w_next = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE:  if (start) w_next = S_RUN;
                S_RUN:   if (hit)
                             w_next = (r_pos == TARGET) ? S_FLASH : S_IDLE;
                S_FLASH: if (w_flash_end) w_next = S_RUN;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_pos_d = r_pos;
        if (w_go)
            w_pos_d = start_pos(dir);
        else if (w_flash_end)
            w_pos_d = start_pos(r_dir);
        else if (w_step)
            w_pos_d = pos_step(r_pos, r_dir);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pos <= POS_MIN;
            r_dir <= 1'b0;
            r_ftk <= 4'd0;
            score <= 4'd0;
        end else begin
            r_pos <= w_pos_d;
            if (w_go) begin
                r_dir <= dir;
                score <= 4'd0;
            end
            if (w_score_hit) begin
                r_ftk <= 4'd0;
                if (score != 4'd15)
                    score <= score + 4'd1;
            end else if (r_state == S_FLASH && w_tick) begin
                r_ftk <= r_ftk + 4'd1;
            end
        end
    end

    always_comb begin
        w_n_d     = n_out;
        w_pulse_d = 1'b1;
        w_busy_d  = 1'b0;
        unique case (w_next)
            S_RUN: begin
                w_n_d     = {4'd0, w_pos_d};
                w_pulse_d = 1'b0;
                w_busy_d  = 1'b1;
            end
            S_FLASH: begin
                w_n_d     = LED_ALL;
                w_pulse_d = (r_state == S_FLASH) ? (pulse_out ^ w_tick)
                                                 : 1'b0;
                w_busy_d  = 1'b1;
            end
            default: begin
                w_n_d     = n_out;
                w_pulse_d = 1'b1;
                w_busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            n_out     <= 7'd0;
            pulse_out <= 1'b1;
            busy      <= 1'b0;
        end else begin
            n_out     <= w_n_d;
            pulse_out <= w_pulse_d;
            busy      <= w_busy_d;
        end
    end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Bench for led_seq_ctrl: vector table, corner sequences, random vs model.
// Honours LED_SEQ_SPEEDUP_EN when the design is built with it.
module tb_led_seq_ctrl;

    localparam int P0 = 8;

    logic       clk = 1'b0;
    logic       rst, start, stop, dir, hit;
    logic [6:0] n_out;
    logic       pulse_out;
    logic [3:0] score;
    logic       busy;

    always #5 clk = ~clk;

    led_seq_ctrl #(
        .TICK_DIV    (24'd8),
        .TARGET      (3'd5),
        .FLASH_TICKS (4'd4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .dir       (dir),
        .hit       (hit),
        .n_out     (n_out),
        .pulse_out (pulse_out),
        .score     (score),
        .busy      (busy)
    );

    int checks = 0;
    int errors = 0;

    // reference model: mode 0 idle, 1 run, 2 flash; m_t = cycles in mode
    int m_mode = 0, m_t = 0, m_dir = 0, m_score = 0;
    int m_n = 0, m_pulse = 1, m_busy = 0, m_lvl = 0, m_plvl = 0;
    bit m_nchk = 1'b1;

    function automatic int mper();
        return P0 >> m_plvl;
    endfunction

    function automatic int mpos();
        int k;
        k = (m_t / mper()) % 6;
        return (m_dir != 0) ? 5 - k : k;
    endfunction

    task automatic model_step();
        if (rst) begin
            m_mode = 0; m_score = 0; m_n = 0; m_nchk = 1'b1;
            m_lvl = 0; m_plvl = 0;
        end else if (stop) begin
            if (m_mode != 0) m_nchk = 1'b0;
            m_mode = 0;
        end else begin
            case (m_mode)
                0: if (start) begin
                    m_mode = 1; m_t = 0; m_dir = int'(dir); m_score = 0;
                    m_lvl = 0; m_plvl = 0;
                end
                1: if (hit) begin
                    if (mpos() == 5) begin
                        m_mode = 2; m_t = 0;
                        if (m_score < 15) m_score++;
                        if (m_lvl < 3) m_lvl++;
                    end else begin
                        m_mode = 0; m_nchk = 1'b0;
                    end
                end else begin
                    m_t++;
                end
                default: begin
                    m_t++;
                    if (m_t == 4 * mper()) begin
                        m_mode = 1; m_t = 0;
`ifdef LED_SEQ_SPEEDUP_EN
                        m_plvl = m_lvl;
`endif
                    end
                end
            endcase
        end
        case (m_mode)
            1: begin m_n = mpos(); m_pulse = 0; m_busy = 1; m_nchk = 1'b1; end
            2: begin
                m_n = 6; m_pulse = (m_t / mper()) % 2; m_busy = 1;
                m_nchk = 1'b1;
            end
            default: begin m_pulse = 1; m_busy = 0; end
        endcase
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp,
                     $time);
        end
    endtask

    task automatic cyc(input bit r, input bit s, input bit sp,
                       input bit d, input bit h);
        rst = r; start = s; stop = sp; dir = d; hit = h;
        @(posedge clk);
        model_step();
        @(negedge clk);
        rst = 1'b0; start = 1'b0; stop = 1'b0; hit = 1'b0;
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
    endtask

    task automatic chk_all(input string nm, input int en, input int ep,
                           input int es, input int eb);
        if (en >= 0) chk({nm, ".n"}, int'(n_out), en);
        chk({nm, ".pulse"}, int'(pulse_out), ep);
        chk({nm, ".score"}, int'(score), es);
        chk({nm, ".busy"}, int'(busy), eb);
    endtask

    typedef struct {
        bit r, s, sp, d, h;
        int cnt;
        int en, ep, es, eb;
    } vec_t;

    vec_t tbl[$];

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; dir = 1'b0; hit = 1'b0;
        @(negedge clk);

`ifndef LED_SEQ_SPEEDUP_EN
        tbl.push_back('{1, 0, 0, 0, 0,  1,  0, 1, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 0,  3,  0, 1, 0, 0});
        tbl.push_back('{0, 1, 0, 0, 0,  1,  0, 0, 0, 1});
        tbl.push_back('{0, 0, 0, 0, 0,  7,  0, 0, 0, 1});
        tbl.push_back('{0, 0, 0, 0, 0,  1,  1, 0, 0, 1});
        tbl.push_back('{0, 0, 0, 0, 0,  8,  2, 0, 0, 1});
        tbl.push_back('{0, 0, 0, 0, 0, 24,  5, 0, 0, 1});
        tbl.push_back('{0, 0, 0, 0, 0,  8,  0, 0, 0, 1});
        tbl.push_back('{0, 0, 0, 0, 0, 40,  5, 0, 0, 1});
        tbl.push_back('{0, 0, 0, 0, 1,  1,  6, 0, 1, 1});
        tbl.push_back('{0, 0, 0, 0, 0,  8,  6, 1, 1, 1});
        tbl.push_back('{0, 0, 0, 0, 0,  8,  6, 0, 1, 1});
        tbl.push_back('{0, 0, 0, 0, 0,  8,  6, 1, 1, 1});
        tbl.push_back('{0, 0, 0, 0, 0,  7,  6, 1, 1, 1});
        tbl.push_back('{0, 0, 0, 0, 0,  1,  0, 0, 1, 1});
        tbl.push_back('{0, 0, 0, 0, 0, 40,  5, 0, 1, 1});
        tbl.push_back('{0, 0, 0, 0, 1,  1,  6, 0, 2, 1});
        tbl.push_back('{0, 0, 0, 0, 0, 32,  0, 0, 2, 1});
        tbl.push_back('{0, 0, 0, 0, 0, 40,  5, 0, 2, 1});
        tbl.push_back('{0, 0, 0, 0, 1,  1,  6, 0, 3, 1});
        tbl.push_back('{0, 0, 0, 0, 0, 32,  0, 0, 3, 1});
        tbl.push_back('{0, 0, 0, 0, 0, 16,  2, 0, 3, 1});
        tbl.push_back('{0, 0, 0, 0, 1,  1, -1, 1, 3, 0});
        tbl.push_back('{0, 0, 0, 0, 0,  5, -1, 1, 3, 0});
        tbl.push_back('{0, 1, 0, 1, 0,  1,  5, 0, 0, 1});
        tbl.push_back('{0, 0, 0, 0, 0,  8,  4, 0, 0, 1});
        tbl.push_back('{0, 0, 0, 0, 0, 32,  0, 0, 0, 1});
        tbl.push_back('{0, 0, 0, 0, 0,  8,  5, 0, 0, 1});
        tbl.push_back('{1, 0, 0, 0, 0,  1,  0, 1, 0, 0});

        foreach (tbl[i]) begin
            for (int c = 0; c < tbl[i].cnt; c++)
                cyc(tbl[i].r, tbl[i].s, tbl[i].sp, tbl[i].d, tbl[i].h);
            chk_all($sformatf("vec%0d", i), tbl[i].en, tbl[i].ep,
                    tbl[i].es, tbl[i].eb);
        end

        // stop together with a valid hit
        cyc(0, 1, 0, 0, 0);
        idle_n(40);
        chk("stopA.pre_n", int'(n_out), 5);
        cyc(0, 0, 1, 0, 1);
        chk_all("stopA", -1, 1, 0, 0);

        // valid hit on the same cycle as a tick
        cyc(0, 1, 0, 0, 0);
        idle_n(47);
        cyc(0, 0, 0, 0, 1);
        chk_all("hitTick", 6, 0, 1, 1);
        idle_n(31);
        chk_all("hitTick.flash", 6, 1, 1, 1);
        idle_n(1);
        chk_all("hitTick.back", 0, 0, 1, 1);

        // start while busy
        idle_n(8);
        cyc(0, 1, 0, 1, 0);
        chk_all("startBusy", 1, 0, 1, 1);
        idle_n(7);
        chk_all("startBusy.next", 2, 0, 1, 1);
        cyc(0, 0, 1, 0, 0);
        chk_all("stop", -1, 1, 1, 0);

        // reset mid-run
        cyc(0, 1, 0, 0, 0);
        idle_n(20);
        cyc(1, 0, 0, 0, 0);
        chk_all("rstRun", 0, 1, 0, 0);
`else
        // four hits: periods 8, 4, 2, 1 then stays at 1
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        idle_n(40);
        cyc(0, 0, 0, 0, 1);
        chk_all("spd1", 6, 0, 1, 1);
        idle_n(32);
        chk_all("spd1.back", 0, 0, 1, 1);
        idle_n(20);
        chk("spd2.pre_n", int'(n_out), 5);
        cyc(0, 0, 0, 0, 1);
        idle_n(16);
        chk_all("spd2.back", 0, 0, 2, 1);
        idle_n(10);
        chk("spd3.pre_n", int'(n_out), 5);
        cyc(0, 0, 0, 0, 1);
        idle_n(8);
        chk_all("spd3.back", 0, 0, 3, 1);
        idle_n(5);
        chk("spd4.pre_n", int'(n_out), 5);
        cyc(0, 0, 0, 0, 1);
        idle_n(4);
        chk_all("spd4.back", 0, 0, 4, 1);
        idle_n(1);
        chk("spd4.step", int'(n_out), 1);
`endif

        // randomized traffic against the model
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 4000; i++) begin
            bit r, s, sp, d, h;
            r  = ($urandom % 500) == 0;
            sp = ($urandom % 300) == 0;
            s  = ($urandom % 16) == 0;
            d  = 1'($urandom % 2);
            if (m_mode == 1 && mpos() == 5)
                h = ($urandom % 4) == 0;
            else
                h = ($urandom % 40) == 0;
            cyc(r, s, sp, d, h);
            if (m_nchk) chk("rnd.n", int'(n_out), m_n);
            chk("rnd.pulse", int'(pulse_out), m_pulse);
            chk("rnd.score", int'(score), m_score);
            chk("rnd.busy", int'(busy), m_busy);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
